pp_line_reader: RTL and testbench
=================================

Name: pp_line_reader

Overview:
- Read-side controller for the ping-pong line buffer in the scaler path.
- Watches the writer's `we` strobe and detects line completion on the `we` falling edge. This is the same event that flips the buffer toggle.
- After each completion it issues `re`/`raddr` to read the finished line out of the RAM, then streams the pixels downstream on a valid/ready interface.
- It absorbs the 1-cycle synchronous RAM read latency under backpressure with a small output FIFO, and flags line overruns.

Parameters:
- ADDR_W, 11, RAM address width; a line is at most 2^ADDR_W-1 pixels.
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2 for this design.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- line_len  in  ADDR_W  pixels per line; sampled at line start; 0 means ignore the line.
- wr_we  in  1  copy of the writer's `we`, used for falling-edge detection.
- re  out  1  RAM read enable.
- raddr  out  ADDR_W  RAM read address.
- rdata  in  DATA_W  RAM read data, valid 1 cycle after `re`.
- m_valid  out  1  output pixel valid.
- m_data  out  DATA_W  output pixel.
- m_last  out  1  marks the final pixel of a line (qualified by `m_valid`).
- m_ready  in  1  downstream accept.
- busy  out  1  high while the state is not IDLE.
- overrun  out  1  1-cycle pulse on a line completion that arrives during READ.
- overrun_sticky  out  1  set by `overrun`; cleared only by reset.

Behaviour:
- Reset values:
  - Outputs `re`, `raddr`, `m_valid`, `m_data`, `m_last`, `busy`, `overrun` and `overrun_sticky` are all 0.
  - Internal state is also cleared: `we_prev`=0, `pending`=0, FIFO empty, in-flight flag cleared, state=IDLE.
- Reset mid-line drops all data in flight and returns to IDLE immediately.
- Edge detect: `we_prev` is registered from `wr_we`. `done = we_prev & ~wr_we`, evaluated each cycle.
- State machine:
  - IDLE:
    - On `done` (or `pending`=1) with `line_len`!=0: latch `len = line_len`, clear `pending`, set `cnt`=0, go to READ.
    - With `line_len`=0: the event is discarded and the block stays in IDLE.
  - READ:
    - Issue rule: `re`=1 when `(occ + inflight - pop) < 2`, where `pop = m_valid & m_ready`.
    - Each issued read drives `raddr = cnt`, then increments `cnt`.
    - The issue with `cnt == len-1` tags that read as last and moves to DRAIN.
  - DRAIN:
    - No new reads are issued.
    - Go to IDLE when the FIFO is empty, nothing is in flight, and the last pixel has been popped.
- Transition latency:
  - IDLE to READ takes 1 cycle after the clock edge at which `done` is sampled.
  - With the FIFO empty, `re` is high in the first READ cycle.
- Datapath:
  - `inflight` is set by `re` and cleared the next cycle.
  - In the cycle after `re`, `rdata` and its last tag are written into the FIFO.
  - `m_valid` first rises 2 cycles after the first `re`.
  - With `m_ready`=1 held, throughput is 1 pixel/cycle with no bubbles.
  - FIFO push and pop in the same cycle are allowed.
  - The FIFO never overflows; the issue rule guarantees it.
- Output hold: `m_data` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- Events during a line:
  - `done` in READ: pulse `overrun` and set `overrun_sticky`. The current line continues unchanged and the event is not queued.
  - `done` in DRAIN: set `pending`. The next line starts from IDLE on the cycle after DRAIN exits.
  - `done` on the same cycle as the DRAIN to IDLE exit: treated as `pending`; it is not lost.
- Addressing: `raddr` never exceeds `len-1`; `cnt` has ADDR_W bits and does not wrap.
- `line_len` changes mid-line have no effect; only the value latched at line start is used.

Decomposition:
- Shared package `scaler_pkg` holds ADDR_W, DATA_W, the state encoding localparams (IDLE=0, READ=1, DRAIN=2) and the 720P default `line_len` constant 1280.
- One sub-module: `sync_fifo2`, a 2-entry FIFO carrying {last, data} with count output.
- Edge detect, FSM and issue logic live in the top level.

Test Plan:
- Reset then idle: assert `reset` with `wr_we` toggling → all outputs 0, `re` never asserted.
- Basic line: `line_len`=4, RAM preloaded with addr n holding 0x10+n, `wr_we` 1→0, `m_ready`=1:
  - `re` is high for 4 consecutive cycles with `raddr` 0,1,2,3.
  - `m_data` is 0x10..0x13 on consecutive cycles, `m_last` only on 0x13.
  - `busy` falls the cycle after the last pop.
- Backpressure: `line_len`=8, `m_ready` alternating 1/0 → all 8 pixels delivered in order, each stable while stalled, `raddr` never skips, FIFO never exceeds 2.
- Overrun: `done` event during READ of a 16-pixel line → `overrun` pulses 1 cycle, `overrun_sticky`=1, and the line still outputs exactly 16 pixels.
- Pending: `done` arrives during DRAIN → the second line starts automatically after DRAIN; both lines complete, with exactly 2 `m_last` pulses.
- Reset mid-line: assert `reset` after 3 pixels of 10 → outputs 0, state IDLE. A fresh `done` afterwards reads from `raddr` 0.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared constants for the scaler line-buffer path: bus widths,
// read-controller state encoding and the default 720p line length.
package scaler_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LINE_LEN_720P = 11'd1280;

endpackage

// File: rtl/pp_line_reader_sync_fifo2.sv
// Two-entry synchronous FIFO. The head entry is always visible on
// head, and count reports occupancy so the producer can throttle itself.
// Push and pop in the same cycle are allowed.
module sync_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slots [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = slots[rd_ptr];

  // Storage, pointers and occupancy; the producer never pushes into a full FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/pp_line_reader.sv
// Read side of the ping-pong line buffer. A falling edge on the writer's
// we marks a finished line; the finished line is then read out of the
// synchronous RAM and streamed downstream over valid/ready. A 2-entry
// FIFO soaks up the one-cycle RAM latency when downstream stalls.
module pp_line_reader import scaler_pkg::*; #(
  parameter int ADDR_W     = scaler_pkg::ADDR_W,
  parameter int DATA_W     = scaler_pkg::DATA_W,
  parameter int FIFO_DEPTH = scaler_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] line_len,
  input  logic              wr_we,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              overrun,
  output logic              overrun_sticky
);

  logic              we_prev;
  logic              done;
  logic [1:0]        state;
  logic              pending;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] cnt;
  logic              inflight;
  logic              inflight_last;
  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        committed;
  logic              last_issue;
  logic              drain_exit;

  assign done = we_prev & ~wr_we;

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = fifo_head[DATA_W-1:0];
  assign m_last  = m_valid & fifo_head[DATA_W];
  assign busy    = (state != ST_IDLE);

  // Entries that will be held after this cycle: stored plus in flight, minus the one leaving
  assign committed  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign re         = (state == ST_READ) && (committed < 3'(FIFO_DEPTH));
  assign raddr      = re ? cnt : '0;
  assign last_issue = re && (cnt == len - ADDR_W'(1));
  assign drain_exit = (state == ST_DRAIN) && !inflight && (fifo_count == {1'b0, pop});

  // Remember the previous we so its falling edge can be seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_prev <= 1'b0;
    end else begin
      we_prev <= wr_we;
    end
  end

  // Line sequencing: start on a completion, issue reads, then drain the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      len     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (done || pending) begin
            pending <= 1'b0;
            if (line_len != '0) begin
              len   <= line_len;
              cnt   <= '0;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (re) begin
            cnt <= cnt + ADDR_W'(1);
            if (last_issue) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (done) begin
            pending <= 1'b1;
          end
          if (drain_exit) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A completion while lines are still being read means the writer lapped us
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun        <= 1'b0;
      overrun_sticky <= 1'b0;
    end else begin
      overrun        <= done && (state == ST_READ);
      overrun_sticky <= overrun_sticky | (done && (state == ST_READ));
    end
  end

  // Track the read whose data arrives from the RAM this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= re;
      inflight_last <= last_issue;
    end
  end

  sync_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data({inflight_last, rdata}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_pp_line_reader.sv
// Bench for pp_line_reader: a line-level model predicts every output on
// every cycle, and directed scenarios pin the model with literal values.
module tb_pp_line_reader;
  import scaler_pkg::*;

  localparam int AW = scaler_pkg::ADDR_W;
  localparam int DW = scaler_pkg::DATA_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] line_len = '0;
  logic          wr_we = 1'b0;
  logic          re;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          overrun;
  logic          overrun_sticky;

  pp_line_reader dut (
    .clk           (clk),
    .reset         (reset),
    .line_len      (line_len),
    .wr_we         (wr_we),
    .re            (re),
    .raddr         (raddr),
    .rdata         (rdata),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_sticky(overrun_sticky)
  );

  // Free-running clock
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Synchronous RAM: data for a read appears the cycle after re
  always @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  // Line-level model state: reads issued, pixels consumed, queued events
  bit mdl_active, mdl_pending, mdl_ovr_next, mdl_sticky, mdl_prev_we;
  int mdl_len, mdl_iss, mdl_iss_prev, mdl_popped;

  // Observation log used by the directed scenarios
  int obs_re, obs_pops, obs_lasts, obs_ovr, cyc, first_re_cyc, last_re_cyc;
  int re_addr_q[$];
  int pop_data_q[$];
  int pop_last_q[$];

  bit done_s, exp_valid, pop_s, exp_re, exp_last, leave;
  int exp_raddr;

  // Per-cycle compare against the model, sampled mid-cycle on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (re) begin
      obs_re++;
      re_addr_q.push_back(int'(raddr));
      if (first_re_cyc < 0) first_re_cyc = cyc;
      last_re_cyc = cyc;
    end
    if (m_valid && m_ready) begin
      obs_pops++;
      pop_data_q.push_back(int'(m_data));
      pop_last_q.push_back(int'(m_last));
      if (m_last) obs_lasts++;
    end
    if (overrun) obs_ovr++;

    if (reset) begin
      mdl_active = 0; mdl_pending = 0; mdl_ovr_next = 0; mdl_sticky = 0; mdl_prev_we = 0;
      mdl_len = 0; mdl_iss = 0; mdl_iss_prev = 0; mdl_popped = 0;
      check_output("reset_outputs",
                   {re, raddr, m_valid, m_data, m_last, busy, overrun, overrun_sticky}, 0);
    end else begin
      done_s    = mdl_prev_we && !wr_we;
      exp_valid = mdl_active && (mdl_iss_prev > mdl_popped);
      pop_s     = exp_valid && m_ready;
      exp_re    = mdl_active && (mdl_iss < mdl_len) &&
                  ((mdl_iss - mdl_popped - (pop_s ? 1 : 0)) < 2);
      exp_raddr = exp_re ? mdl_iss : 0;
      exp_last  = exp_valid && (mdl_popped == mdl_len - 1);

      check_output("re", re, exp_re);
      check_output("raddr", raddr, exp_raddr);
      check_output("m_valid", m_valid, exp_valid);
      check_output("m_last", m_last, exp_last);
      check_output("busy", busy, mdl_active);
      check_output("overrun", overrun, mdl_ovr_next);
      check_output("overrun_sticky", overrun_sticky, mdl_sticky);
      if (exp_valid) check_output("m_data", m_data, mem[mdl_popped]);

      mdl_ovr_next = 0;
      if (!mdl_active) begin
        if (done_s || mdl_pending) begin
          mdl_pending = 0;
          if (line_len != 0) begin
            mdl_active = 1; mdl_len = int'(line_len);
            mdl_iss = 0; mdl_iss_prev = 0; mdl_popped = 0;
          end
        end
      end else begin
        if (done_s) begin
          if (mdl_iss < mdl_len) begin
            mdl_ovr_next = 1;
            mdl_sticky = 1;
          end else begin
            mdl_pending = 1;
          end
        end
        leave = (mdl_iss == mdl_len) && (mdl_popped + (pop_s ? 1 : 0) == mdl_len);
        mdl_iss_prev = mdl_iss;
        mdl_iss += exp_re ? 1 : 0;
        mdl_popped += pop_s ? 1 : 0;
        if (leave) mdl_active = 0;
      end
      mdl_prev_we = wr_we;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_re = 0; obs_pops = 0; obs_lasts = 0; obs_ovr = 0; first_re_cyc = -1; last_re_cyc = -1;
    re_addr_q.delete(); pop_data_q.delete(); pop_last_q.delete();
  endtask

  // Writer finishes a line: one we pulse whose falling edge is the completion
  task automatic apply_stimulus(input int len);
    line_len = AW'(len);
    wr_we = 1'b1;
    step(1);
    wr_we = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin
      step(1);
      i++;
    end
    check_output("idle_within_budget", (i < budget), 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i = 0;
    while (obs_pops < n && i < budget) begin
      step(1);
      i++;
    end
    check_output("pops_within_budget", (i < budget), 1);
  endtask

  task automatic wait_lasts(input int n, input int budget);
    int i = 0;
    while (obs_lasts < n && i < budget) begin
      step(1);
      i++;
    end
    check_output("lasts_within_budget", (i < budget), 1);
  endtask

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized soak
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = (i < 64) ? DW'(8'h10 + i) : DW'($urandom);
    clear_obs();

    line_len = LINE_LEN_720P;
    for (int i = 0; i < 6; i++) begin
      wr_we = ~wr_we;
      step(1);
    end
    wr_we = 1'b0;
    step(1);
    check_output("reset_no_re", obs_re, 0);
    reset = 1'b0;
    step(3);
    check_output("idle_after_reset", busy, 0);

    clear_obs();
    m_ready = 1'b1;
    apply_stimulus(4);
    wait_idle(50);
    check_output("basic_re_count", obs_re, 4);
    check_output("basic_re_span", last_re_cyc - first_re_cyc, 3);
    check_output("basic_pops", obs_pops, 4);
    if (re_addr_q.size() == 4 && pop_data_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output("basic_raddr", re_addr_q[i], i);
        check_output("basic_data", pop_data_q[i], 32'h10 + i);
        check_output("basic_last", pop_last_q[i], (i == 3) ? 1 : 0);
      end
    end

    clear_obs();
    apply_stimulus(0);
    step(5);
    check_output("zero_len_busy", busy, 0);
    check_output("zero_len_re", obs_re, 0);

    clear_obs();
    m_ready = 1'b0;
    apply_stimulus(8);
    for (int i = 0; i < 100 && busy; i++) begin
      m_ready = ~m_ready;
      step(1);
    end
    m_ready = 1'b1;
    check_output("bp_idle", busy, 0);
    check_output("bp_pops", obs_pops, 8);
    if (pop_data_q.size() == 8 && re_addr_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_output("bp_data", pop_data_q[i], 32'h10 + i);
        check_output("bp_raddr", re_addr_q[i], i);
      end
    end

    clear_obs();
    apply_stimulus(16);
    step(3);
    apply_stimulus(16);
    wait_idle(100);
    step(3);
    check_output("ovr_pulses", obs_ovr, 1);
    check_output("ovr_sticky", overrun_sticky, 1);
    check_output("ovr_pops", obs_pops, 16);
    check_output("ovr_lasts", obs_lasts, 1);
    check_output("ovr_not_queued", busy, 0);

    clear_obs();
    m_ready = 1'b0;
    apply_stimulus(2);
    step(4);
    apply_stimulus(3);
    m_ready = 1'b1;
    wait_lasts(2, 100);
    wait_idle(50);
    check_output("pend_lasts", obs_lasts, 2);
    check_output("pend_pops", obs_pops, 5);
    check_output("pend_no_overrun", obs_ovr, 0);
    if (pop_data_q.size() == 5) begin
      for (int i = 0; i < 3; i++) check_output("pend_line2_data", pop_data_q[2 + i], 32'h10 + i);
    end

    clear_obs();
    apply_stimulus(10);
    wait_pops(3, 50);
    reset = 1'b1;
    #1;
    check_output("midreset_busy", busy, 0);
    check_output("midreset_valid", m_valid, 0);
    check_output("midreset_sticky", overrun_sticky, 0);
    step(2);
    reset = 1'b0;
    step(2);
    clear_obs();
    apply_stimulus(5);
    wait_idle(50);
    check_output("restart_re_count", obs_re, 5);
    check_output("restart_pops", obs_pops, 5);
    if (re_addr_q.size() > 0) check_output("restart_first_raddr", re_addr_q[0], 0);
    if (pop_data_q.size() > 0) check_output("restart_first_data", pop_data_q[0], 32'h10);

    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    for (int c = 0; c < 4000; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) wr_we = ~wr_we;
      if ($urandom_range(0, 7) == 0) line_len = AW'($urandom_range(0, 40));
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      else reset = 1'b0;
      step(1);
    end
    reset = 1'b0;
    wr_we = 1'b0;
    m_ready = 1'b1;
    step(2);
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
